// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - serialise keep-qualified wide words into narrow beats
//
// Purpose:
//   Takes one wide word of T_DATA_RATIO lanes and emits only the kept lanes,
//   lowest lane first, as T_DATA_WIDTH-wide beats. The packet last flag is
//   re-attached to the final kept lane of a word that carries last.
//
// Optional feature macro: STREAM_DOWNSIZE_ZERO_BUBBLE_EN
//   When defined, a new word may be accepted in the same cycle as the final
//   beat of the current word (s_ready_o then depends on m_ready_i), giving
//   one beat per clock sustained. When undefined, s_ready_o is high only
//   while EMPTY, so there is one idle cycle between words.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_data_i   input word, unpacked array of lanes; lane 0 is first in time
//   s_keep_i   per-lane valid mask
//   s_last_i   word ends a packet
//   s_valid_i  input word valid
//   s_ready_o  block can accept a word
//   m_data_o   narrow output beat
//   m_last_o   beat ends a packet
//   m_valid_o  output beat valid
//   m_ready_i  downstream accepts the beat
//   err_o      one-cycle pulse when a keep==0, last==1 word is dropped

module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    err_o
);

    localparam int PTR_W = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] REM_ONE = {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q;
    logic [T_DATA_RATIO-1:0] rem_d;
    logic                    last_q;
    logic                    last_d;
    logic                    err_q;
    logic                    err_d;
    logic                    load;
    logic [PTR_W-1:0]        ptr;
    logic                    rem_one;
    logic                    word_acc;
    logic                    beat_acc;

    // Lowest set bit of rem: scanning downwards lets the lowest index win.
    always_comb begin
        ptr = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                ptr = PTR_W'(i);
            end
        end
    end

    // Exactly one lane left: the beat on the output is the last of the word.
    assign rem_one = (rem_q != '0) && ((rem_q & (rem_q - REM_ONE)) == '0);

    assign m_valid_o = (state_q == BUSY);
    assign m_data_o  = (state_q == BUSY) ? data_q[ptr] : '0;
    assign m_last_o  = (state_q == BUSY) & last_q & rem_one;
    assign err_o     = err_q;

`ifdef STREAM_DOWNSIZE_ZERO_BUBBLE_EN
    // Accept the next word while the final beat of this one leaves.
    assign s_ready_o = (state_q == EMPTY) | ((state_q == BUSY) & m_ready_i & rem_one);
`else
    assign s_ready_o = (state_q == EMPTY);
`endif

    assign word_acc = s_valid_i & s_ready_o;
    assign beat_acc = m_valid_o & m_ready_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        last_d  = last_q;
        err_d   = 1'b0;
        load    = 1'b0;

        if (beat_acc) begin
            rem_d = rem_q & ~(REM_ONE << ptr);
            if (rem_d == '0) begin
                state_d = EMPTY;
            end
        end

        // A word is only accepted when EMPTY or while the final beat leaves,
        // so the current word is always finished at this point.
        if (word_acc) begin
            if (s_keep_i != '0) begin
                load    = 1'b1;
                rem_d   = s_keep_i;
                last_d  = s_last_i;
                state_d = BUSY;
            end else begin
                rem_d   = '0;
                state_d = EMPTY;
                err_d   = s_last_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rem_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            err_q   <= err_d;
            if (load) begin
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    data_q[i] <= s_data_i[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// tb/tb_stream_downsize.sv - self-checking bench for stream_downsize
module tb_stream_downsize;

    localparam int W = 4;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] s_data [R];
    logic [R-1:0] s_keep;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       l;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  k;
        logic        l;
        int          n;
        logic [15:0] e;
    } vec_t;

    vec_t tbl[7];

    stream_downsize #(
        .T_DATA_WIDTH(W),
        .T_DATA_RATIO(R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: any beat accepted by downstream must match the queue head.
    always @(negedge clk) begin
        #1;
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got data=%0h last=%0b, required no beat", m_data, m_last);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_data", {28'd0, m_data}, {28'd0, mon_e.d});
                chk("beat_last", {31'd0, m_last}, {31'd0, mon_e.l});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_word(input logic [15:0] d, input logic [3:0] k, input logic l);
        int  n;
        bit  acc;
        for (int i = 0; i < R; i++) s_data[i] = d[4*i +: 4];
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            #1;
            acc = s_ready;
            @(posedge clk);
            if (!acc) begin
                @(negedge clk);
                n++;
            end
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Counts falling edges until the output is idle and the scoreboard empty.
    task automatic drain(output int span);
        int n;
        n = 0;
        #1;
        while ((m_valid || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
        span = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int span;
        int t0;
        int exp_span;

        tbl[0] = '{d: 16'h0010, k: 4'b0011, l: 1'b0, n: 2, e: 16'h0010};
        tbl[1] = '{d: 16'h0002, k: 4'b0001, l: 1'b1, n: 1, e: 16'h0002};
        tbl[2] = '{d: 16'h00BA, k: 4'b0011, l: 1'b1, n: 2, e: 16'h00BA};
        tbl[3] = '{d: 16'h8765, k: 4'b1010, l: 1'b1, n: 2, e: 16'h0086};
        tbl[4] = '{d: 16'hFEDC, k: 4'b1111, l: 1'b0, n: 4, e: 16'hFEDC};
        tbl[5] = '{d: 16'h4321, k: 4'b1001, l: 1'b1, n: 2, e: 16'h0041};
        tbl[6] = '{d: 16'h0900, k: 4'b0100, l: 1'b1, n: 1, e: 16'h0009};

        for (int i = 0; i < R; i++) s_data[i] = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_data", {28'd0, m_data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < tbl[v].n; j++) begin
                sb.push_back('{d: tbl[v].e[4*j +: 4], l: tbl[v].l && (j == tbl[v].n - 1)});
            end
            send_word(tbl[v].d, tbl[v].k, tbl[v].l);
            #1;
            chk("first_beat_latency", {31'd0, m_valid}, 32'd1);
            drain(span);
            chk("beat_span", span, tbl[v].n);
            @(negedge clk);
        end

        // Backpressure: beat held stable, no new word accepted.
        m_ready = 1'b0;
        sb.push_back('{d: 4'h3, l: 1'b0});
        sb.push_back('{d: 4'h4, l: 1'b0});
        send_word(16'h0043, 4'b0011, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_valid", {31'd0, m_valid}, 32'd1);
            chk("bp_data", {28'd0, m_data}, 32'd3);
            chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        drain(span);
        chk("bp_span", span, 2);
        @(negedge clk);

        // Empty words: error pulse only when last is set.
        send_word(16'h0000, 4'b0000, 1'b1);
        #1;
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_no_beat", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        @(negedge clk);
        send_word(16'h0000, 4'b0000, 1'b0);
        #1;
        chk("err_silent", {31'd0, err}, 32'd0);
        @(negedge clk);
        #1;
        chk("err_silent2", {31'd0, err}, 32'd0);
        chk("drop_no_beat", {31'd0, m_valid}, 32'd0);
        @(negedge clk);

        // Asynchronous reset after the first of two beats.
        sb.push_back('{d: 4'h9, l: 1'b0});
        send_word(16'h00C9, 4'b0011, 1'b1);
        #1;
        chk("mid_first", {28'd0, m_data}, 32'd9);
        @(posedge clk);
        #2;
        chk("mid_second", {28'd0, m_data}, 32'hC);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_data", {28'd0, m_data}, 32'd0);
        chk("arst_last", {31'd0, m_last}, 32'd0);
        chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("post_rst_idle", {31'd0, m_valid}, 32'd0);
            chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
            @(negedge clk);
        end

        // Back-to-back words: bubble between words unless zero-bubble build.
        sb.push_back('{d: 4'h1, l: 1'b0});
        sb.push_back('{d: 4'h2, l: 1'b0});
        sb.push_back('{d: 4'h3, l: 1'b0});
        sb.push_back('{d: 4'h4, l: 1'b1});
        send_word(16'h0021, 4'b0011, 1'b0);
        t0 = cyc;
        send_word(16'h0043, 4'b0011, 1'b1);
        drain(span);
`ifdef STREAM_DOWNSIZE_ZERO_BUBBLE_EN
        exp_span = 4;
`else
        exp_span = 5;
`endif
        chk("b2b_span", cyc - t0, exp_span);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
